// File: rtl/msrv32_pc_unit_pkg.sv
// -----------------------------------------------------------------------------
// msrv32_pc_unit_pkg
// Shared definitions for the program-counter unit:
//   pc_src_e   - PC source select encodings driven by the decode/trap logic
//   pc_state_e - fetch FSM state encoding (BOOT, RUN, STALL)
// -----------------------------------------------------------------------------
package msrv32_pc_unit_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    PC_BOOT = 2'b00,
    PC_EPC  = 2'b01,
    PC_TRAP = 2'b10,
    PC_NEXT = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STALL = 2'b10
  } pc_state_e;

endpackage

// File: rtl/msrv32_pc_mux.sv
// -----------------------------------------------------------------------------
// msrv32_pc_mux
// Combinational next-PC source multiplexer.
//   pc_src_i       - source select (boot / epc / trap / next)
//   epc_i          - mret return address
//   trap_address_i - trap vector target
//   branch_taken_i - taken branch or jump this cycle
//   iadder_i       - branch/jump target from the immediate adder
//   pc_plus_4_i    - current PC + 4
//   next_pc_o      - selected next PC
// Optional feature: MSRV32_PC_MISALIGN_TRAP_EN keeps bit 1 of the branch
// target (so a misaligned target can be flagged and trapped); otherwise the
// target is forced to a 4-byte boundary.
// -----------------------------------------------------------------------------
module msrv32_pc_mux
  import msrv32_pc_unit_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
  input  logic [1:0]  pc_src_i,
  input  logic [31:0] epc_i,
  input  logic [31:0] trap_address_i,
  input  logic        branch_taken_i,
  input  logic [31:0] iadder_i,
  input  logic [31:0] pc_plus_4_i,
  output logic [31:0] next_pc_o
);

  pc_src_e     src;
  logic [31:0] branch_target;
  logic [31:0] seq_target;

  assign src = pc_src_e'(pc_src_i);

`ifdef MSRV32_PC_MISALIGN_TRAP_EN
  assign branch_target = {iadder_i[31:1], 1'b0};
  logic unused_iadder;
  assign unused_iadder = iadder_i[0];
`else
  assign branch_target = {iadder_i[31:2], 2'b00};
  logic unused_iadder;
  assign unused_iadder = ^iadder_i[1:0];
`endif

  assign seq_target = branch_taken_i ? branch_target : pc_plus_4_i;

  always_comb begin
    next_pc_o = seq_target;
    case (src)
      PC_BOOT: next_pc_o = BOOT_ADDRESS;
      PC_EPC:  next_pc_o = epc_i;
      PC_TRAP: next_pc_o = trap_address_i;
      default: next_pc_o = seq_target;
    endcase
  end

endmodule

// File: rtl/msrv32_pc_unit.sv
// -----------------------------------------------------------------------------
// msrv32_pc_unit
// Program counter, fetch FSM and stall-time redirect capture.
//   ms_riscv32_mp_clk_in  - clock, rising edge
//   ms_riscv32_mp_rst_in  - synchronous active-high reset
//   pc_src_in             - PC source select (00 boot, 01 epc, 10 trap, 11 next)
//   epc_in                - mret return address
//   trap_address_in       - trap vector target
//   branch_taken_in       - taken branch/jump this cycle
//   iadder_in             - branch/jump target
//   ahb_ready_in          - instruction bus ready, low stalls fetch
//   pc_out                - registered PC of the current instruction
//   pc_plus_4_out         - pc_out + 4 (link value)
//   i_addr_out            - next fetch address (combinational)
//   fetch_valid_out       - i_addr_out is a valid request
//   misaligned_instr_out  - taken target not 4-byte aligned (registered)
//   dbg_state_o           - current FSM state, for observation
// Optional feature: MSRV32_PC_MISALIGN_TRAP_EN enables misaligned_instr_out;
// when undefined the flag is tied low and branch targets are word aligned.
//
// Handshake: a fetch is issued on every cycle where fetch_valid_out is high;
// the bus accepts it in that cycle (ahb_ready_in high) and the PC advances on
// that edge. While ahb_ready_in is low nothing advances and any redirect seen
// is remembered so it is not lost when the bus resumes.
// -----------------------------------------------------------------------------
module msrv32_pc_unit
  import msrv32_pc_unit_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic [1:0]  pc_src_in,
  input  logic [31:0] epc_in,
  input  logic [31:0] trap_address_in,
  input  logic        branch_taken_in,
  input  logic [31:0] iadder_in,
  input  logic        ahb_ready_in,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus_4_out,
  output logic [31:0] i_addr_out,
  output logic        fetch_valid_out,
  output logic        misaligned_instr_out,
  output pc_state_e   dbg_state_o
);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  // Set when the captured redirect may still be replaced by a later trap.
  logic        pend_ovr_q, pend_ovr_d;

  logic [31:0] mux_pc;
  logic [31:0] next_pc;
  logic        live_redirect;
  logic        active;
  logic        load;

  assign pc_plus_4_out = pc_q + 32'd4;
  assign pc_out        = pc_q;
  assign dbg_state_o   = state_q;

  msrv32_pc_mux #(
    .BOOT_ADDRESS (BOOT_ADDRESS)
  ) u_mux (
    .pc_src_i       (pc_src_in),
    .epc_i          (epc_in),
    .trap_address_i (trap_address_in),
    .branch_taken_i (branch_taken_in),
    .iadder_i       (iadder_in),
    .pc_plus_4_i    (pc_plus_4_out),
    .next_pc_o      (mux_pc)
  );

  assign live_redirect = (pc_src_in != PC_NEXT) || branch_taken_in;
  assign active        = (state_q != ST_BOOT);
  assign load          = active && ahb_ready_in;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:  state_d = ST_RUN;
      ST_RUN:   if (!ahb_ready_in) state_d = ST_STALL;
      ST_STALL: if (ahb_ready_in)  state_d = ST_RUN;
      default:  state_d = ST_BOOT;
    endcase
  end

  // Fetch address and valid. A remembered redirect replaces the sequential
  // target, but a redirect presented live in the same cycle takes precedence.
  always_comb begin
    next_pc         = mux_pc;
    fetch_valid_out = ahb_ready_in;
    if (!active) begin
      next_pc         = BOOT_ADDRESS;
      fetch_valid_out = 1'b0;
    end else if (pend_v_q && !live_redirect) begin
      next_pc = pend_addr_q;
    end
  end

  assign i_addr_out = next_pc;
  assign pc_d       = load ? next_pc : pc_q;

  // Pending redirect: any cycle where the bus holds us off (including the
  // RUN cycle in which ready first drops) records the first redirect; only a
  // trap may replace an earlier epc or branch capture.
  always_comb begin
    pend_v_d    = pend_v_q;
    pend_addr_d = pend_addr_q;
    pend_ovr_d  = pend_ovr_q;
    if (load) begin
      pend_v_d = 1'b0;
    end else if (active && live_redirect) begin
      if (!pend_v_q || (pend_ovr_q && (pc_src_in == PC_TRAP))) begin
        pend_v_d    = 1'b1;
        pend_addr_d = mux_pc;
        pend_ovr_d  = (pc_src_in == PC_EPC) || (pc_src_in == PC_NEXT);
      end
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q     <= ST_BOOT;
      pc_q        <= BOOT_ADDRESS;
      pend_v_q    <= 1'b0;
      pend_addr_q <= 32'h0;
      pend_ovr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_v_q    <= pend_v_d;
      pend_addr_q <= pend_addr_d;
      pend_ovr_q  <= pend_ovr_d;
    end
  end

`ifdef MSRV32_PC_MISALIGN_TRAP_EN
  logic mis_q, mis_d;

  // Raised alongside the misaligned PC; the trap unit redirects next cycle.
  assign mis_d = load && branch_taken_in && (pc_src_in == PC_NEXT) && iadder_in[1];

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) mis_q <= 1'b0;
    else                      mis_q <= mis_d;
  end

  assign misaligned_instr_out = mis_q;
`else
  assign misaligned_instr_out = 1'b0;
`endif

endmodule

// File: tb/tb_msrv32_pc_unit.sv
module tb_msrv32_pc_unit;
  import msrv32_pc_unit_pkg::*;

  localparam logic [31:0] BOOT = 32'h0000_0000;
`ifdef MSRV32_PC_MISALIGN_TRAP_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  src = 2'b11;
  logic [31:0] epc = 32'h0;
  logic [31:0] trap = 32'h0;
  logic        br = 1'b0;
  logic [31:0] iadder = 32'h0;
  logic        ready = 1'b1;
  logic [31:0] pc_out, pc_plus_4_out, i_addr_out;
  logic        fetch_valid_out, misaligned_instr_out;
  pc_state_e   dbg_state;

  always #5 clk = ~clk;

  msrv32_pc_unit #(.BOOT_ADDRESS(BOOT)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .pc_src_in            (src),
    .epc_in               (epc),
    .trap_address_in      (trap),
    .branch_taken_in      (br),
    .iadder_in            (iadder),
    .ahb_ready_in         (ready),
    .pc_out               (pc_out),
    .pc_plus_4_out        (pc_plus_4_out),
    .i_addr_out           (i_addr_out),
    .fetch_valid_out      (fetch_valid_out),
    .misaligned_instr_out (misaligned_instr_out),
    .dbg_state_o          (dbg_state)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  // ---------------- reference model ----------------
  // The PC, whether we are in the post-reset boot cycle, and the list of
  // redirects seen while the bus was holding us off.
  logic [31:0] m_pc = BOOT;
  bit          m_boot = 1'b1;
  bit          m_mis = 1'b0;
  int          cap_src[$];
  logic [31:0] cap_addr[$];

  function automatic bit is_redirect();
    return (src != 2'd3) || br;
  endfunction

  function automatic logic [31:0] live_tgt();
    case (src)
      2'd0: return BOOT;
      2'd1: return epc;
      2'd2: return trap;
      default: begin
        if (!br) return m_pc + 32'd4;
        return MIS_EN ? (iadder & 32'hFFFF_FFFE) : (iadder & 32'hFFFF_FFFC);
      end
    endcase
  endfunction

  // First captured redirect wins, unless it was an epc or branch and a trap
  // arrived after it.
  function automatic logic [31:0] winner();
    if (cap_src[0] == 1 || cap_src[0] == 3)
      for (int i = 1; i < cap_src.size(); i++)
        if (cap_src[i] == 2) return cap_addr[i];
    return cap_addr[0];
  endfunction

  function automatic logic [31:0] exp_iaddr();
    if (m_boot) return BOOT;
    if (!is_redirect() && cap_src.size() > 0) return winner();
    return live_tgt();
  endfunction

  function automatic logic [97:0] exp_vec();
    return {m_pc, exp_iaddr(), m_pc + 32'd4, (m_boot ? 1'b0 : ready), m_mis};
  endfunction

  function automatic logic [97:0] obs_vec();
    return {pc_out, i_addr_out, pc_plus_4_out, fetch_valid_out, misaligned_instr_out};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic [1:0] s, input logic [31:0] e,
                       input logic [31:0] t, input logic b, input logic [31:0] ia,
                       input logic rd);
    rst = r; src = s; epc = e; trap = t; br = b; iadder = ia; ready = rd;
    #1;
  endtask

  task automatic tick();
    logic [31:0] nxt;
    @(posedge clk);
    nxt = exp_iaddr();
    if (rst) begin
      m_pc = BOOT; m_boot = 1'b1; m_mis = 1'b0;
      cap_src.delete(); cap_addr.delete();
    end else if (m_boot) begin
      m_boot = 1'b0; m_mis = 1'b0;
    end else if (ready) begin
      m_mis = MIS_EN && br && (src == 2'd3) && iadder[1];
      m_pc = nxt;
      cap_src.delete(); cap_addr.delete();
    end else begin
      m_mis = 1'b0;
      if (is_redirect()) begin
        cap_src.push_back(int'(src));
        cap_addr.push_back(live_tgt());
      end
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(1, 2'($urandom_range(0, 3)), $urandom, $urandom, 1'b1, $urandom, 1'b1);
    tick();
    drive(1, 2'd2, 32'h1234_5678, 32'h8000_0000, 1'b1, 32'h102, 1'b0);
    checks++;
    if ({pc_out, i_addr_out, fetch_valid_out, misaligned_instr_out} !== {BOOT, BOOT, 2'b00}) begin
      errors++;
      $display("FAIL reset_state: got pc=%h iaddr=%h fv=%b mis=%b, want pc=%h iaddr=%h fv=0 mis=0",
               pc_out, i_addr_out, fetch_valid_out, misaligned_instr_out, BOOT, BOOT);
    end
    tick();
    drive(0, 2'd3, 0, 0, 1'b0, 0, 1'b1);
    checks++;
    if ({pc_out, i_addr_out, fetch_valid_out} !== {32'h0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL boot_cycle: got pc=%h iaddr=%h fv=%b, want 0/0/0", pc_out, i_addr_out, fetch_valid_out);
    end
    tick();
    checks++;
    if ({pc_out, i_addr_out, fetch_valid_out} !== {32'h0, 32'h4, 1'b1}) begin
      errors++;
      $display("FAIL first_run: got pc=%h iaddr=%h fv=%b, want 0/4/1", pc_out, i_addr_out, fetch_valid_out);
    end
    tick();
    checks++;
    if (pc_out !== 32'h4) begin errors++; $display("FAIL seq_pc4: got %h want 00000004", pc_out); end
    tick();
    checks++;
    if (pc_out !== 32'h8) begin errors++; $display("FAIL seq_pc8: got %h want 00000008", pc_out); end
  endtask

  task automatic test_branch();
    drive(0, 2'd1, 32'h100, 0, 1'b0, 0, 1'b1);
    tick();
    checks++;
    if (pc_out !== 32'h100) begin errors++; $display("FAIL epc_load: got %h want 00000100", pc_out); end
    drive(0, 2'd3, 0, 0, 1'b1, 32'h241, 1'b1);
    checks++;
    if (i_addr_out !== 32'h240) begin errors++; $display("FAIL branch_iaddr: got %h want 00000240", i_addr_out); end
    tick();
    checks++;
    if (pc_out !== 32'h240) begin errors++; $display("FAIL branch_pc: got %h want 00000240", pc_out); end
  endtask

  task automatic test_stall_trap();
    for (int c = 0; c < 3; c++) begin
      if (c == 0) drive(0, 2'd2, 0, 32'h8000_0000, 1'b0, 0, 1'b0);
      else        drive(0, 2'd3, 0, 0, 1'b0, 0, 1'b0);
      checks++;
      if ({pc_out, fetch_valid_out} !== {32'h240, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold c%0d: got pc=%h fv=%b want 00000240/0", c, pc_out, fetch_valid_out);
      end
      tick();
    end
    drive(0, 2'd3, 0, 0, 1'b0, 0, 1'b1);
    checks++;
    if ({i_addr_out, fetch_valid_out} !== {32'h8000_0000, 1'b1}) begin
      errors++;
      $display("FAIL resume_iaddr: got %h fv=%b want 80000000/1", i_addr_out, fetch_valid_out);
    end
    tick();
    checks++;
    if (pc_out !== 32'h8000_0000) begin errors++; $display("FAIL resume_pc: got %h want 80000000", pc_out); end
  endtask

  task automatic test_stall_priority();
    drive(0, 2'd3, 0, 0, 1'b0, 0, 1'b1);
    tick(); // pc -> 8000_0004
    drive(0, 2'd3, 0, 0, 1'b1, 32'h300, 1'b0);        tick();
    drive(0, 2'd2, 0, 32'h8000_0000, 1'b0, 0, 1'b0);  tick();
    drive(0, 2'd1, 32'h500, 0, 1'b0, 0, 1'b0);        tick();
    checks++;
    if (pc_out !== 32'h8000_0004) begin errors++; $display("FAIL prio_hold: got %h want 80000004", pc_out); end
    drive(0, 2'd3, 0, 0, 1'b0, 0, 1'b1);
    checks++;
    if (i_addr_out !== 32'h8000_0000) begin errors++; $display("FAIL prio_trap_wins: got %h want 80000000", i_addr_out); end
    tick();
    tick();
    checks++;
    if (pc_out !== 32'h8000_0004) begin errors++; $display("FAIL prio_clear: got %h want 80000004", pc_out); end
  endtask

  task automatic test_live_wins();
    drive(0, 2'd3, 0, 0, 1'b1, 32'h300, 1'b0);
    tick();
    drive(0, 2'd1, 32'h600, 0, 1'b0, 0, 1'b1);
    checks++;
    if (i_addr_out !== 32'h600) begin errors++; $display("FAIL live_wins_iaddr: got %h want 00000600", i_addr_out); end
    tick();
    drive(0, 2'd3, 0, 0, 1'b0, 0, 1'b1);
    tick();
    checks++;
    if (pc_out !== 32'h604) begin errors++; $display("FAIL live_wins_clear: got %h want 00000604", pc_out); end
  endtask

  task automatic test_reset_mid_stall();
    drive(0, 2'd2, 0, 32'h8000_0000, 1'b0, 0, 1'b0); tick();
    drive(1, 2'd3, 0, 0, 1'b0, 0, 1'b0);              tick();
    drive(0, 2'd3, 0, 0, 1'b0, 0, 1'b1);              tick(); // boot cycle
    checks++;
    if (i_addr_out !== 32'h4) begin errors++; $display("FAIL rst_discard_iaddr: got %h want 00000004", i_addr_out); end
    tick();
    checks++;
    if (pc_out !== 32'h4) begin errors++; $display("FAIL rst_discard_pc: got %h want 00000004", pc_out); end
  endtask

  task automatic test_wrap();
    drive(0, 2'd1, 32'hFFFF_FFFC, 0, 1'b0, 0, 1'b1);
    tick();
    drive(0, 2'd3, 0, 0, 1'b0, 0, 1'b1);
    checks++;
    if ({pc_plus_4_out, i_addr_out} !== 64'h0) begin
      errors++;
      $display("FAIL wrap_plus4: got p4=%h iaddr=%h want 0/0", pc_plus_4_out, i_addr_out);
    end
    tick();
    checks++;
    if (pc_out !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h want 00000000", pc_out); end
  endtask

  task automatic test_misalign();
    logic [31:0] want = MIS_EN ? 32'h102 : 32'h100;
    drive(0, 2'd3, 0, 0, 1'b1, 32'h102, 1'b1);
    checks++;
    if (i_addr_out !== want) begin errors++; $display("FAIL mis_iaddr: got %h want %h", i_addr_out, want); end
    tick();
    drive(0, 2'd3, 0, 0, 1'b0, 0, 1'b1);
    checks++;
    if ({pc_out, misaligned_instr_out} !== {want, MIS_EN}) begin
      errors++;
      $display("FAIL mis_flag: got pc=%h mis=%b want %h/%b", pc_out, misaligned_instr_out, want, MIS_EN);
    end
    tick();
    checks++;
    if (misaligned_instr_out !== 1'b0) begin errors++; $display("FAIL mis_one_cycle: got %b want 0", misaligned_instr_out); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    for (int n = 0; n < 400; n++) begin
      int r = $urandom_range(0, 9);
      drive(($urandom_range(0, 49) == 0), (r < 6) ? 2'd3 : 2'(r - 6), $urandom, $urandom,
            ($urandom_range(0, 4) == 0), $urandom, ($urandom_range(0, 9) < 7));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rand_outputs n=%0d: got %h want %h (pc,iaddr,pc4,fv,mis)", n, obs_vec(), exp_vec());
      end
      exp_q.push_back(rst ? BOOT : ((!m_boot && ready) ? exp_iaddr() : m_pc));
      tick();
      exp_pc = exp_q.pop_front();
      checks++;
      if (pc_out !== exp_pc) begin
        errors++;
        $display("FAIL rand_pc n=%0d: got %h want %h", n, pc_out, exp_pc);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_branch();
    test_stall_trap();
    test_stall_priority();
    test_live_wins();
    test_reset_mid_stall();
    test_wrap();
    test_misalign();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
